// File: rtl/intdiv.sv
`default_nettype none
// ============================================================================
// Module   : intdiv
// Purpose  : Iterative restoring divider, signed/unsigned, ALU-style z/n/v.
//            Optional `INTDIV_EARLY_OUT_EN` skips iteration for trivial cases.
// Revision : 1.0  initial release
// ============================================================================
module intdiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             z_out,
    output logic             n_out,
    output logic             v_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    c_cnt_init = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_min      = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_q, r_prem, r_dvs;
    logic             r_sgn, r_qneg, r_rneg, r_div0, r_ovf;
    logic [CW-1:0]    r_cnt;

    logic             w_a_neg, w_b_neg, w_div0, w_ovf;
    logic [WIDTH-1:0] w_a_mag, w_b_mag, w_q_fix, w_r_fix;
    logic [WIDTH:0]   w_shift, w_diff;
    logic [WIDTH-1:0] w_quot_res, w_rem_res;
    logic             w_v_res;

    assign w_a_neg = r_sgn & r_a[WIDTH-1];
    assign w_b_neg = r_sgn & r_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -r_a : r_a;
    assign w_b_mag = w_b_neg ? -r_b : r_b;
    assign w_div0  = (r_b == '0);
    assign w_ovf   = r_sgn && (r_a == c_min) && (r_b == '1);

    // Partial remainder stays below the divisor, so WIDTH+1 bits hold the
    // shifted value and the top bit of the difference is its sign.
    assign w_shift = {r_prem, r_q[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};

    assign w_q_fix = r_qneg ? -r_q : r_q;
    assign w_r_fix = r_rneg ? -r_prem : r_prem;

    always_comb begin
        w_quot_res = w_q_fix;
        w_rem_res  = w_r_fix;
        w_v_res    = 1'b0;
        if (r_div0) begin
            w_quot_res = '1;
            w_rem_res  = r_a;
            w_v_res    = 1'b1;
        end else if (r_ovf) begin
            w_quot_res = c_min;
            w_rem_res  = '0;
            w_v_res    = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_q     <= '0;
            r_prem  <= '0;
            r_dvs   <= '0;
            r_sgn   <= 1'b0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_div0  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            quot    <= '0;
            rem     <= '0;
            z_out   <= 1'b0;
            n_out   <= 1'b0;
            v_out   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= in1;
                        r_b     <= in2;
                        r_sgn   <= sgn;
                        busy    <= 1'b1;
                        r_state <= S_PREP;
                    end
                end
                S_PREP: begin
                    r_dvs  <= w_b_mag;
                    r_qneg <= w_a_neg ^ w_b_neg;
                    r_rneg <= w_a_neg;
                    r_div0 <= w_div0;
                    r_ovf  <= w_ovf;
                    r_cnt  <= c_cnt_init;
`ifdef INTDIV_EARLY_OUT_EN
                    if (w_div0 || w_ovf || (w_b_mag > w_a_mag)) begin
                        r_q     <= '0;
                        r_prem  <= w_a_mag;
                        r_state <= S_FIX;
                    end else begin
                        r_q     <= w_a_mag;
                        r_prem  <= '0;
                        r_state <= S_ITER;
                    end
`else
                    r_q     <= w_a_mag;
                    r_prem  <= '0;
                    r_state <= S_ITER;
`endif
                end
                S_ITER: begin
                    if (!w_diff[WIDTH]) begin
                        r_prem <= w_diff[WIDTH-1:0];
                    end else begin
                        r_prem <= w_shift[WIDTH-1:0];
                    end
                    r_q   <= {r_q[WIDTH-2:0], ~w_diff[WIDTH]};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    quot    <= w_quot_res;
                    rem     <= w_rem_res;
                    z_out   <= (w_quot_res == '0);
                    n_out   <= w_quot_res[WIDTH-1];
                    v_out   <= w_v_res;
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_intdiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_intdiv
// Purpose  : Directed self-checking bench for intdiv (WIDTH = 32).
// Revision : 1.0  initial release
// ============================================================================
module tb_intdiv;

    localparam int W        = 32;
    localparam int LAT_FULL = W + 3;
`ifdef INTDIV_EARLY_OUT_EN
    localparam int LAT_EO   = 3;
`else
    localparam int LAT_EO   = W + 3;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sgn = 1'b0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         busy, done, z_out, n_out, v_out;
    logic [W-1:0] quot, rem;

    int n_cmp = 0;
    int n_bad = 0;

    intdiv #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start(start), .sgn(sgn),
        .in1(in1), .in2(in2), .busy(busy), .done(done),
        .quot(quot), .rem(rem), .z_out(z_out), .n_out(n_out), .v_out(v_out)
    );

    always #5 clk = ~clk;

    // Drive a request so it is sampled at the end of cycle 0.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, output logic busy_c0);
        @(negedge clk);
        in1 = a; in2 = b; sgn = s; start = 1'b1;
        busy_c0 = busy;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns the cycle in which done is seen, or -1 on timeout.
    task automatic wait_done(output int lat, output logic busy_ok);
        lat = -1;
        busy_ok = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, done, z_out, n_out, v_out, quot, rem} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b z=%b n=%b v=%b q=%h r=%h, expected all 0",
                     busy, done, z_out, n_out, v_out, quot, rem);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        int   lat;
        logic b0, bok;
        issue(32'd100, 32'd7, 1'b0, b0);
        wait_done(lat, bok);
        n_cmp++;
        if (b0 !== 1'b0) begin n_bad++; $display("FAIL u100_7_busy_c0: got %b expected 0", b0); end
        n_cmp++;
        if (lat !== LAT_FULL) begin n_bad++; $display("FAIL u100_7_latency: got %0d expected %0d", lat, LAT_FULL); end
        n_cmp++;
        if (bok !== 1'b1) begin n_bad++; $display("FAIL u100_7_busy_span: busy dropped, got %b expected 1", bok); end
        n_cmp++;
        if ({quot, rem, z_out, n_out, v_out} !== {32'd14, 32'd2, 3'b000}) begin
            n_bad++;
            $display("FAIL u100_7_result: got q=%h r=%h znv=%b%b%b expected q=0000000e r=00000002 znv=000",
                     quot, rem, z_out, n_out, v_out);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, busy, quot, rem} !== {1'b0, 1'b0, 32'd14, 32'd2}) begin
            n_bad++;
            $display("FAIL u100_7_hold: got done=%b busy=%b q=%h r=%h expected done=0 busy=0 q=0000000e r=00000002",
                     done, busy, quot, rem);
        end
    endtask

    task automatic test_signed();
        int   lat;
        logic b0, bok;
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, b0);
        wait_done(lat, bok);
        n_cmp++;
        if ({quot, rem, n_out, v_out, z_out} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF, 3'b100}) begin
            n_bad++;
            $display("FAIL s_m7_2: got q=%h r=%h n=%b v=%b z=%b expected q=fffffffd r=ffffffff n=1 v=0 z=0",
                     quot, rem, n_out, v_out, z_out);
        end
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, b0);
        wait_done(lat, bok);
        n_cmp++;
        if ({quot, rem, n_out, v_out} !== {32'hFFFF_FFFD, 32'd1, 2'b10}) begin
            n_bad++;
            $display("FAIL s_7_m2: got q=%h r=%h n=%b v=%b expected q=fffffffd r=00000001 n=1 v=0",
                     quot, rem, n_out, v_out);
        end
    endtask

    task automatic test_overflow();
        int   lat;
        logic b0, bok;
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, b0);
        wait_done(lat, bok);
        n_cmp++;
        if ({quot, rem, v_out, n_out, z_out} !== {32'h8000_0000, 32'd0, 3'b110}) begin
            n_bad++;
            $display("FAIL s_min_m1: got q=%h r=%h v=%b n=%b z=%b expected q=80000000 r=00000000 v=1 n=1 z=0",
                     quot, rem, v_out, n_out, z_out);
        end
        n_cmp++;
        if (lat !== LAT_EO) begin n_bad++; $display("FAIL s_min_m1_latency: got %0d expected %0d", lat, LAT_EO); end
        // Unsigned: 0x80000000 < 0xFFFFFFFF, so quotient 0 and remainder the dividend.
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, b0);
        wait_done(lat, bok);
        n_cmp++;
        if ({quot, rem, v_out, z_out} !== {32'd0, 32'h8000_0000, 2'b01}) begin
            n_bad++;
            $display("FAIL u_min_m1: got q=%h r=%h v=%b z=%b expected q=00000000 r=80000000 v=0 z=1",
                     quot, rem, v_out, z_out);
        end
    endtask

    task automatic test_div_zero();
        int   lat;
        logic b0, bok;
        for (int s = 0; s < 2; s++) begin
            issue(32'd5, 32'd0, s[0], b0);
            wait_done(lat, bok);
            n_cmp++;
            if ({quot, rem, v_out, n_out, z_out} !== {32'hFFFF_FFFF, 32'd5, 3'b110}) begin
                n_bad++;
                $display("FAIL div0_sgn%0d: got q=%h r=%h v=%b n=%b z=%b expected q=ffffffff r=00000005 v=1 n=1 z=0",
                         s, quot, rem, v_out, n_out, z_out);
            end
            n_cmp++;
            if (lat !== LAT_EO) begin n_bad++; $display("FAIL div0_sgn%0d_latency: got %0d expected %0d", s, lat, LAT_EO); end
        end
    endtask

    task automatic test_small();
        int   lat;
        logic b0, bok;
        issue(32'd3, 32'd10, 1'b0, b0);
        wait_done(lat, bok);
        n_cmp++;
        if ({quot, rem, z_out, n_out, v_out} !== {32'd0, 32'd3, 3'b100}) begin
            n_bad++;
            $display("FAIL u3_10: got q=%h r=%h znv=%b%b%b expected q=00000000 r=00000003 znv=100",
                     quot, rem, z_out, n_out, v_out);
        end
        n_cmp++;
        if (lat !== LAT_EO) begin n_bad++; $display("FAIL u3_10_latency: got %0d expected %0d", lat, LAT_EO); end
    endtask

    task automatic test_ignore_start();
        int   lat;
        logic b0;
        issue(32'd100, 32'd7, 1'b0, b0);
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 10) begin
                in1 = 32'd999; in2 = 32'd5; start = 1'b1;
            end else if (c == 11) begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        n_cmp++;
        if (lat !== LAT_FULL) begin n_bad++; $display("FAIL ignore_start_latency: got %0d expected %0d", lat, LAT_FULL); end
        n_cmp++;
        if ({quot, rem} !== {32'd14, 32'd2}) begin
            n_bad++;
            $display("FAIL ignore_start_result: got q=%h r=%h expected q=0000000e r=00000002", quot, rem);
        end
    endtask

    task automatic test_reset_mid();
        int   lat;
        logic b0, bok;
        issue(32'd1000, 32'd3, 1'b0, b0);
        for (int c = 1; c <= 12; c++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, z_out, n_out, v_out, quot, rem} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: got busy=%b done=%b z=%b n=%b v=%b q=%h r=%h, expected all 0",
                     busy, done, z_out, n_out, v_out, quot, rem);
        end
        rst_n = 1'b1;
        issue(32'd9, 32'd3, 1'b0, b0);
        wait_done(lat, bok);
        n_cmp++;
        if ({quot, rem} !== {32'd3, 32'd0} || lat !== LAT_FULL) begin
            n_bad++;
            $display("FAIL after_reset_9_3: got q=%h r=%h lat=%0d expected q=00000003 r=00000000 lat=%0d",
                     quot, rem, lat, LAT_FULL);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic b0, bok;
        issue(32'd20, 32'd4, 1'b0, b0);
        wait_done(lat, bok);
        // Held start from the DONE cycle into the following IDLE cycle.
        in1 = 32'd21; in2 = 32'd5; sgn = 1'b0; start = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_c0: got %b expected 0", busy); end
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bok);
        n_cmp++;
        if ({quot, rem} !== {32'd4, 32'd1} || lat !== LAT_FULL) begin
            n_bad++;
            $display("FAIL b2b_21_5: got q=%h r=%h lat=%0d expected q=00000004 r=00000001 lat=%0d",
                     quot, rem, lat, LAT_FULL);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_div_zero();
        test_small();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
